axi_rid_scheduler: RTL and testbench

Read-ID scheduler for the DDR controller's AXI read path. Records each accepted AR request's ID and burst length in arrival order. Tags in-order read-data beats returning from the DDR datapath with the matching RID and RLAST. Sits between the AXI slave AR/R channels and the DDR read-data return path; the data payload itself is routed elsewhere.

---
 rtl/rid_sched_pkg.sv | 14 +
 rtl/rid_fifo.sv | 68 ++++++
 rtl/axi_rid_scheduler.sv | 92 +++++++++
 tb/tb_axi_rid_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rid_sched_pkg.sv
// Shared types and default sizing for the AXI read-ID scheduler.
package rid_sched_pkg;

  localparam int unsigned ID_W_DEF  = 4;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned DEPTH_DEF = 8;

  // One queued read burst: requesting ID and ARLEN (beats-1).
  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [LEN_W_DEF-1:0] len;
  } rid_entry_t;

endpackage

// File: rtl/rid_fifo.sv
// In-order synchronous FIFO with a per-slot valid/data view.
module rid_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [DW-1:0]                  din_i,
  input  logic                           pop_i,
  output logic [DW-1:0]                  dout_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic [DEPTH-1:0]               vld_o,
  output logic [DEPTH-1:0][DW-1:0]       data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q;
  logic                     push_ok, pop_ok;
  logic [PTR_W-1:0]         off;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign data_o  = mem_q;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset since validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    vld_o = '0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rd_ptr_q;
      vld_o[i] = (CNT_W'(off) < count_q);
    end
  end

endmodule

// File: rtl/axi_rid_scheduler.sv
// Tags in-order DDR read beats with RID/RLAST from the queue of accepted AR requests.
module axi_rid_scheduler
  import rid_sched_pkg::*;
#(
  parameter int unsigned ID_W  = ID_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         ar_valid,
  output logic                         ar_ready,
  input  logic [ID_W-1:0]              ar_id,
  input  logic [LEN_W-1:0]             ar_len,
  input  logic                         beat_valid,
  output logic                         beat_ready,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic [ID_W-1:0]              r_id,
  output logic                         r_last,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic [2**ID_W-1:0]           id_pending
);

  localparam int unsigned DW = ID_W + LEN_W;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } entry_t;

  entry_t                   push_ent, head;
  logic [DEPTH-1:0]         ent_vld;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic                     full, empty, live;
  logic                     push, pop, xfer;
  logic [LEN_W-1:0]         cnt_q, cnt_d;

  // n_rst is active-high here: the interface is live only while it is low.
  assign live     = !n_rst;
  assign push_ent = '{id: ar_id, len: ar_len};

  assign ar_ready   = live && !full;
  assign r_valid    = live && beat_valid && !empty;
  assign beat_ready = live && r_ready && !empty;
  assign r_id       = (live && !empty) ? head.id : '0;
  assign r_last     = live && !empty && (cnt_q == head.len);

  assign push = ar_valid && ar_ready;
  assign xfer = r_valid && r_ready;
  assign pop  = xfer && r_last;

  rid_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (n_rst),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding),
    .vld_o   (ent_vld),
    .data_o  (ent_data)
  );

  // Head beat counter: advance per transferred beat, restart on the last one.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) cnt_d = r_last ? '0 : cnt_q + LEN_W'(1);
  end

  // Beat counter register.
  always_ff @(posedge clk) begin
    if (n_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Per-ID pending map rebuilt from the live queue slots.
  always_comb begin
    id_pending = '0;
    if (live) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_vld[i]) id_pending[ent_data[i][DW-1 -: ID_W]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rid_scheduler.sv
// Directed, table-driven bench for axi_rid_scheduler (default parameters).
module tb_axi_rid_scheduler;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic        beat_valid, beat_ready;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic        r_last;
  logic [3:0]  outstanding;
  logic [15:0] id_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rid_scheduler #(
    .ID_W  (4),
    .LEN_W (8),
    .DEPTH (8)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .ar_valid    (ar_valid),
    .ar_ready    (ar_ready),
    .ar_id       (ar_id),
    .ar_len      (ar_len),
    .beat_valid  (beat_valid),
    .beat_ready  (beat_ready),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_id        (r_id),
    .r_last      (r_last),
    .outstanding (outstanding),
    .id_pending  (id_pending)
  );

  typedef struct packed {
    logic        rst;
    logic        arv;
    logic [3:0]  aid;
    logic [7:0]  alen;
    logic        bv;
    logic        rr;
    logic        arr;
    logic        rv;
    logic        br;
    logic [3:0]  rid;
    logic        rl;
    logic [3:0]  outs;
    logic [15:0] idp;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic arv, input logic [3:0] aid,
                              input logic [7:0] alen, input logic bv, input logic rr,
                              input logic arr, input logic rv, input logic br,
                              input logic [3:0] rid, input logic rl, input logic [3:0] outs,
                              input logic [15:0] idp);
    vec_t v;
    v.rst = rst; v.arv = arv; v.aid = aid; v.alen = alen; v.bv = bv; v.rr = rr;
    v.arr = arr; v.rv = rv; v.br = br; v.rid = rid; v.rl = rl; v.outs = outs; v.idp = idp;
    return v;
  endfunction

  // Drive one cycle of inputs after the falling edge, then compare all outputs
  // mid-cycle, before the next rising edge commits the state change.
  task automatic apply(input vec_t v, input string tag, input int idx);
    logic [27:0] act, exp;
    @(negedge clk);
    n_rst = v.rst; ar_valid = v.arv; ar_id = v.aid; ar_len = v.alen;
    beat_valid = v.bv; r_ready = v.rr;
    #2;
    act = {ar_ready, r_valid, beat_ready, r_id, r_last, outstanding, id_pending};
    exp = {v.arr, v.rv, v.br, v.rid, v.rl, v.outs, v.idp};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got arr=%b rv=%b br=%b rid=%h rl=%b out=%0d idp=%h, expected arr=%b rv=%b br=%b rid=%h rl=%b out=%0d idp=%h",
               tag, idx, ar_ready, r_valid, beat_ready, r_id, r_last, outstanding, id_pending,
               v.arr, v.rv, v.br, v.rid, v.rl, v.outs, v.idp);
    end
  endtask

  vec_t tbl[27];

  initial begin
    n_rst = 1'b1; ar_valid = 1'b0; ar_id = '0; ar_len = '0; beat_valid = 1'b0; r_ready = 1'b0;
    @(negedge clk);

    //            rst arv aid   alen  bv rr  arr rv br rid   rl out idp
    // reset held with active inputs
    tbl[0]  = mk(1, 1, 4'h5, 8'd0, 1, 1,  0, 0, 0, 4'h0, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 1, 4'h5, 8'd0, 1, 1,  0, 0, 0, 4'h0, 0, 0, 16'h0000);
    tbl[2]  = mk(0, 0, 4'h0, 8'd0, 0, 0,  1, 0, 0, 4'h0, 0, 0, 16'h0000);
    // single burst id=3 len=3
    tbl[3]  = mk(0, 1, 4'h3, 8'd3, 0, 0,  1, 0, 0, 4'h0, 0, 0, 16'h0000);
    tbl[4]  = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h3, 0, 1, 16'h0008);
    tbl[5]  = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h3, 0, 1, 16'h0008);
    tbl[6]  = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h3, 0, 1, 16'h0008);
    tbl[7]  = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h3, 1, 1, 16'h0008);
    tbl[8]  = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 0, 0, 4'h0, 0, 0, 16'h0000);
    // backpressure mid-burst id=A len=2
    tbl[9]  = mk(0, 1, 4'hA, 8'd2, 0, 0,  1, 0, 0, 4'h0, 0, 0, 16'h0000);
    tbl[10] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'hA, 0, 1, 16'h0400);
    tbl[11] = mk(0, 0, 4'h0, 8'd0, 1, 0,  1, 1, 0, 4'hA, 0, 1, 16'h0400);
    tbl[12] = mk(0, 0, 4'h0, 8'd0, 0, 1,  1, 0, 1, 4'hA, 0, 1, 16'h0400);
    tbl[13] = mk(0, 0, 4'h0, 8'd0, 1, 0,  1, 1, 0, 4'hA, 0, 1, 16'h0400);
    tbl[14] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'hA, 0, 1, 16'h0400);
    tbl[15] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'hA, 1, 1, 16'h0400);
    // push on the same edge as the head's last beat, no bubble after
    tbl[16] = mk(0, 1, 4'h1, 8'd1, 0, 0,  1, 0, 0, 4'h0, 0, 0, 16'h0000);
    tbl[17] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h1, 0, 1, 16'h0002);
    tbl[18] = mk(0, 1, 4'h6, 8'd0, 1, 1,  1, 1, 1, 4'h1, 1, 1, 16'h0002);
    tbl[19] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h6, 1, 1, 16'h0040);
    tbl[20] = mk(0, 0, 4'h0, 8'd0, 0, 0,  1, 0, 0, 4'h0, 0, 0, 16'h0000);
    // repeated ID stays ordered: id2 len0 then id2 len1
    tbl[21] = mk(0, 1, 4'h2, 8'd0, 0, 0,  1, 0, 0, 4'h0, 0, 0, 16'h0000);
    tbl[22] = mk(0, 1, 4'h2, 8'd1, 0, 0,  1, 0, 0, 4'h2, 1, 1, 16'h0004);
    tbl[23] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h2, 1, 2, 16'h0004);
    tbl[24] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h2, 0, 1, 16'h0004);
    tbl[25] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 1, 1, 4'h2, 1, 1, 16'h0004);
    tbl[26] = mk(0, 0, 4'h0, 8'd0, 1, 1,  1, 0, 0, 4'h0, 0, 0, 16'h0000);

    for (int i = 0; i < 27; i++) apply(tbl[i], "table", i);

    // Fill: eight len-0 bursts with ids 0..7, no beats.
    for (int i = 0; i < 8; i++)
      apply(mk(0, 1, 4'(i), 8'd0, 0, 0, 1, 0, 0, 4'h0 | ((i > 0) ? 4'h0 : 4'h0), (i > 0), 4'(i),
               16'((32'd1 << i) - 1)), "fill", i);
    // 9th request refused while full; then a pop in the same cycle must not admit it.
    apply(mk(0, 1, 4'h9, 8'd0, 0, 0, 0, 0, 0, 4'h0, 1, 8, 16'h00FF), "full_hold", 0);
    apply(mk(0, 1, 4'h9, 8'd0, 1, 1, 0, 1, 1, 4'h0, 1, 8, 16'h00FF), "full_pop", 0);
    apply(mk(0, 0, 4'h0, 8'd0, 0, 0, 1, 0, 0, 4'h1, 1, 7, 16'h00FE), "after_pop", 0);
    // Drain the remaining seven in order.
    for (int i = 1; i < 8; i++)
      apply(mk(0, 0, 4'h0, 8'd0, 1, 1, 1, 1, 1, 4'(i), 1, 4'(8 - i),
               16'(16'h00FF & ~((16'd1 << i) - 16'd1))), "drain", i);
    apply(mk(0, 0, 4'h0, 8'd0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 16'h0000), "drained", 0);

    // Reset after 2 of 4 beats of id=4, then a fresh len-1 burst must start at beat 0.
    apply(mk(0, 1, 4'h4, 8'd3, 0, 0, 1, 0, 0, 4'h0, 0, 0, 16'h0000), "mid_rst", 0);
    apply(mk(0, 0, 4'h0, 8'd0, 1, 1, 1, 1, 1, 4'h4, 0, 1, 16'h0010), "mid_rst", 1);
    apply(mk(0, 0, 4'h0, 8'd0, 1, 1, 1, 1, 1, 4'h4, 0, 1, 16'h0010), "mid_rst", 2);
    apply(mk(1, 0, 4'h0, 8'd0, 1, 1, 0, 0, 0, 4'h0, 0, 1, 16'h0000), "mid_rst", 3);
    apply(mk(0, 0, 4'h0, 8'd0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 16'h0000), "mid_rst", 4);
    apply(mk(0, 1, 4'h5, 8'd1, 1, 1, 1, 0, 0, 4'h0, 0, 0, 16'h0000), "mid_rst", 5);
    apply(mk(0, 0, 4'h0, 8'd0, 1, 1, 1, 1, 1, 4'h5, 0, 1, 16'h0020), "mid_rst", 6);
    apply(mk(0, 0, 4'h0, 8'd0, 1, 1, 1, 1, 1, 4'h5, 1, 1, 16'h0020), "mid_rst", 7);
    apply(mk(0, 0, 4'h0, 8'd0, 1, 1, 1, 0, 0, 4'h0, 0, 0, 16'h0000), "mid_rst", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
